// File: rtl/bomb_exp_if.sv
// Pixel, sprite and placement inputs plus bomb/explosion status outputs of bomb_exp_module.
interface bomb_exp_if;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] x_b;
    logic [9:0] y_b;
    logic       place;
    logic       bomb_on;
    logic       exp_on;
    logic       post_exp_active;
    logic       bomb_active;
    logic       exp_done;
    logic [5:0] bomb_tx;
    logic [4:0] bomb_ty;

    modport master (
        output x, y, x_b, y_b, place,
        input  bomb_on, exp_on, post_exp_active, bomb_active, exp_done, bomb_tx, bomb_ty
    );

    modport slave (
        input  x, y, x_b, y_b, place,
        output bomb_on, exp_on, post_exp_active, bomb_active, exp_done, bomb_tx, bomb_ty
    );
endinterface

// File: rtl/bomb_exp_module.sv
// Single player bomb: placement snap, arm/explode/hold timing, and the bomb/flame pixel masks.
module bomb_exp_module #(
    parameter int BOMB_TIME = 200000000,
    parameter int EXP_TIME  = 50000000,
    parameter int POST_TIME = 25000000,
    parameter int RANGE     = 2
) (
    input  logic       clk,
    input  logic       reset,
    bomb_exp_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ARMED, EXPLODE, POST_EXP} state_t;

    localparam logic [27:0] BOMB_LAST = 28'(BOMB_TIME - 1);
    localparam logic [27:0] EXP_LAST  = 28'(EXP_TIME - 1);
    localparam logic [27:0] EXP_PRE   = 28'(EXP_TIME - 2);
    localparam logic [27:0] POST_LAST = 28'(POST_TIME - 1);
    localparam logic [9:0]  X_WALL_L  = 10'd48;
    localparam logic [9:0]  Y_WALL_U  = 10'd31;
    localparam logic [5:0]  RANGE_W   = 6'(RANGE);

    state_t      state;
    logic [27:0] timer;
    logic [5:0]  tx_q;
    logic [4:0]  ty_q;
    logic        active_q;
    logic        post_q;
    logic        done_q;

    // Sprite top-left snapped to the tile containing its centre, clamped to the arena.
    logic [5:0] snap_x, snap_y;
    logic [5:0] snap_tx;
    logic [4:0] snap_ty;

    always_comb begin
        // NOTE: every path assigns snap_tx/snap_ty, so no latch is inferred.
        snap_x = 6'((bus.x_b - (X_WALL_L - 10'd8)) >> 4);
        snap_y = 6'((bus.y_b - (Y_WALL_U - 10'd8)) >> 4);
        if (bus.x_b < X_WALL_L)   snap_tx = '0;
        else if (snap_x > 6'd32)  snap_tx = 6'd32;
        else                      snap_tx = snap_x;
        if (bus.y_b < Y_WALL_U)   snap_ty = '0;
        else if (snap_y > 6'd26)  snap_ty = 5'd26;
        else                      snap_ty = snap_y[4:0];
    end

    // Status outputs are set on the transition into a state so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            tx_q     <= '0;
            ty_q     <= '0;
            active_q <= 1'b0;
            post_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop sees pre-edge values.
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.place) begin
                        state    <= ARMED;
                        timer    <= '0;
                        tx_q     <= snap_tx;
                        ty_q     <= snap_ty;
                        active_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (timer == BOMB_LAST) begin
                        state  <= EXPLODE;
                        timer  <= '0;
                        post_q <= 1'b1;
                        done_q <= (EXP_TIME == 1);
                    end else begin
                        timer <= timer + 28'd1;
                    end
                end
                EXPLODE: begin
                    if (timer == EXP_LAST) begin
                        state <= POST_EXP;
                        timer <= '0;
                    end else begin
                        timer  <= timer + 28'd1;
                        done_q <= (EXP_TIME > 1) && (timer == EXP_PRE);
                    end
                end
                POST_EXP: begin
                    if (timer == POST_LAST) begin
                        state    <= IDLE;
                        timer    <= '0;
                        active_q <= 1'b0;
                        post_q   <= 1'b0;
                    end else begin
                        timer <= timer + 28'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel tile; 6 bits hold every (x-48)>>4 result, so in_arena needs no wider copy.
    logic [5:0] px, py;
    logic [5:0] btx, bty;
    logic [5:0] dx, dy;
    logic       in_arena, centre, h_arm, v_arm;

    always_comb begin
        px       = 6'((bus.x - X_WALL_L) >> 4);
        py       = 6'((bus.y - Y_WALL_U) >> 4);
        btx      = tx_q;
        bty      = {1'b0, ty_q};
        in_arena = (bus.x >= X_WALL_L) && (bus.y >= Y_WALL_U) && (px <= 6'd32) && (py <= 6'd26);
        dx       = (px >= btx) ? (px - btx) : (btx - px);
        dy       = (py >= bty) ? (py - bty) : (bty - py);
        centre   = (px == btx) && (py == bty);
        // Odd rows/columns are flanked by pillars, so that arm never propagates.
        h_arm    = (py == bty) && !bty[0] && (dx <= RANGE_W);
        v_arm    = (px == btx) && !btx[0] && (dy <= RANGE_W);
    end

    assign bus.bomb_on         = (state == ARMED) && in_arena && centre;
    assign bus.exp_on          = (state == EXPLODE) && in_arena && (centre || h_arm || v_arm);
    assign bus.bomb_active     = active_q;
    assign bus.post_exp_active = post_q;
    assign bus.exp_done        = done_q;
    assign bus.bomb_tx         = tx_q;
    assign bus.bomb_ty         = ty_q;

endmodule

// File: tb/tb_bomb_exp_module.sv
// Randomized bench for bomb_exp_module against a phase-count model, plus directed flame-shape checks.
`timescale 1ns/100ps
module tb_bomb_exp_module;
    localparam int BT    = 10;
    localparam int ET    = 5;
    localparam int PT    = 3;
    localparam int RG    = 2;
    localparam int TOTAL = BT + ET + PT;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bomb_exp_if bif ();

    bomb_exp_module #(
        .BOMB_TIME(BT), .EXP_TIME(ET), .POST_TIME(PT), .RANGE(RG)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: a bomb is just "cycles since it was placed" plus its snapped tile.
    bit m_busy = 1'b0;
    int m_n    = 0;
    int m_tx   = 0;
    int m_ty   = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int snap(input int p, input int wall, input int lim);
        int t;
        if (p < wall) return 0;
        t = (p - wall + 8) / 16;
        return (t > lim) ? lim : t;
    endfunction

    function automatic bit in_phase(input int lo, input int hi);
        return m_busy && (m_n >= lo) && (m_n < hi);
    endfunction

    function automatic void model_masks(input int xi, input int yi, output bit b, output bit e);
        int  px, py, dx, dy;
        bit  arena;
        arena = (xi >= 48) && (yi >= 31) && ((xi - 48) / 16 <= 32) && ((yi - 31) / 16 <= 26);
        px = (xi - 48) / 16;
        py = (yi - 31) / 16;
        dx = (px > m_tx) ? px - m_tx : m_tx - px;
        dy = (py > m_ty) ? py - m_ty : m_ty - py;
        b = arena && in_phase(0, BT) && px == m_tx && py == m_ty;
        e = arena && in_phase(BT, BT + ET) &&
            ((px == m_tx && py == m_ty) ||
             (py == m_ty && (m_ty % 2) == 0 && dx <= RG) ||
             (px == m_tx && (m_tx % 2) == 0 && dy <= RG));
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_n    = 0;
            m_tx   = 0;
            m_ty   = 0;
        end else if (m_busy) begin
            m_n++;
            if (m_n == TOTAL) m_busy = 1'b0;
        end else if (bif.place) begin
            m_busy = 1'b1;
            m_n    = 0;
            m_tx   = snap(int'(bif.x_b), 48, 32);
            m_ty   = snap(int'(bif.y_b), 31, 26);
        end
    end

    bit cmp_b, cmp_e;

    always @(negedge clk) begin
        model_masks(int'(bif.x), int'(bif.y), cmp_b, cmp_e);
        check("bomb_active", int'(bif.bomb_active), int'(m_busy));
        check("post_exp_active", int'(bif.post_exp_active), int'(in_phase(BT, TOTAL)));
        check("exp_done", int'(bif.exp_done), int'(m_busy && m_n == BT + ET - 1));
        check("bomb_tx", int'(bif.bomb_tx), m_tx);
        check("bomb_ty", int'(bif.bomb_ty), m_ty);
        check("bomb_on", int'(bif.bomb_on), int'(cmp_b));
        check("exp_on", int'(bif.exp_on), int'(cmp_e));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_pix(input int tx, input int ty);
        bif.x = 10'(48 + 16 * tx + int'($urandom_range(15)));
        bif.y = 10'(31 + 16 * ty + int'($urandom_range(15)));
    endtask

    task automatic probe(input string name, input int tx, input int ty, input int exp_e);
        set_pix(tx, ty);
        #0.2;
        check(name, int'(bif.exp_on), exp_e);
        check({name, "_bomb_on"}, int'(bif.bomb_on), 0);
    endtask

    task automatic arm(input int xb, input int yb);
        bif.x_b   = 10'(xb);
        bif.y_b   = 10'(yb);
        bif.place = 1'b1;
        step();
        bif.place = 1'b0;
    endtask

    initial begin
        int na, np, nd, dk;
        bif.x = '0; bif.y = '0; bif.x_b = '0; bif.y_b = '0; bif.place = 1'b0;
        steps(2);
        check("rst_bomb_active", int'(bif.bomb_active), 0);
        check("rst_post", int'(bif.post_exp_active), 0);
        check("rst_tx", int'(bif.bomb_tx), 0);
        reset = 1'b0;
        steps(2);

        // Bomb at tile (4,6) with place chatter during ARMED/EXPLODE.
        arm(48 + 16 * 4, 31 + 16 * 6);
        check("a_tx", int'(bif.bomb_tx), 4);
        check("a_ty", int'(bif.bomb_ty), 6);
        na = 0; np = 0; nd = 0; dk = -1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) step();
            na += int'(bif.bomb_active);
            np += int'(bif.post_exp_active);
            if (bif.exp_done) begin nd++; dk = k; end
            if (k == 0) begin
                set_pix(4, 6); #0.2;
                check("a_bomb_on_centre", int'(bif.bomb_on), 1);
                set_pix(5, 6); #0.2;
                check("a_bomb_on_side", int'(bif.bomb_on), 0);
            end
            if (k == 10) begin
                for (int t = 2; t <= 6; t++) probe("a_h_arm", t, 6, 1);
                for (int t = 4; t <= 8; t++) probe("a_v_arm", 4, t, 1);
                probe("a_h_end", 7, 6, 0);
                probe("a_v_end", 4, 9, 0);
                probe("a_diag", 5, 5, 0);
            end else begin
                bif.x = 10'($urandom_range(1023));
                bif.y = 10'($urandom_range(1023));
            end
            bif.place = (k < 14) ? 1'($urandom_range(1)) : 1'b0;
            bif.x_b   = 10'($urandom_range(1023));
            bif.y_b   = 10'($urandom_range(1023));
        end
        check("a_active_cycles", na, 18);
        check("a_post_cycles", np, 8);
        check("a_done_pulses", nd, 1);
        check("a_done_cycle", dk, 14);
        check("a_tx_hold", int'(bif.bomb_tx), 4);

        // Odd tx: vertical arm suppressed.
        arm(48 + 16 * 3, 31 + 16 * 6);
        check("b_tx", int'(bif.bomb_tx), 3);
        steps(10);
        for (int t = 1; t <= 5; t++) probe("b_h_arm", t, 6, 1);
        probe("b_v_up", 3, 5, 0);
        probe("b_v_dn", 3, 7, 0);
        probe("b_h_end", 6, 6, 0);
        steps(9);

        // Sprite above/left of the wall clamps to tile (0,0).
        arm(40, 20);
        check("c_tx", int'(bif.bomb_tx), 0);
        check("c_ty", int'(bif.bomb_ty), 0);
        steps(10);
        probe("c_centre", 0, 0, 1);
        probe("c_r1", 1, 0, 1);
        probe("c_r2", 2, 0, 1);
        probe("c_d1", 0, 1, 1);
        probe("c_d2", 0, 2, 1);
        probe("c_r3", 3, 0, 0);
        probe("c_pillar", 1, 1, 0);
        bif.x = 10'd40; bif.y = 10'd36; #0.2;
        check("c_left_of_wall", int'(bif.exp_on), 0);
        steps(9);

        // Far corner clamps to (32,26); arm past the edge is clipped.
        arm(1000, 1000);
        check("d_tx", int'(bif.bomb_tx), 32);
        check("d_ty", int'(bif.bomb_ty), 26);
        steps(10);
        probe("d_centre", 32, 26, 1);
        probe("d_left", 30, 26, 1);
        probe("d_up", 32, 24, 1);
        probe("d_outside", 33, 26, 0);
        steps(9);

        // Reset in the third EXPLODE cycle, then re-arm straight out of reset.
        arm(48 + 16 * 4, 31 + 16 * 6);
        steps(12);
        #1 reset = 1'b1;
        set_pix(0, 0);
        #1;
        check("e_active", int'(bif.bomb_active), 0);
        check("e_post", int'(bif.post_exp_active), 0);
        check("e_done", int'(bif.exp_done), 0);
        check("e_exp_on", int'(bif.exp_on), 0);
        check("e_tx", int'(bif.bomb_tx), 0);
        bif.place = 1'b1;
        bif.x_b   = 10'(48 + 16 * 4);
        bif.y_b   = 10'(31 + 16 * 6);
        #1 reset = 1'b0;
        step();
        bif.place = 1'b0;
        check("e_rearm_active", int'(bif.bomb_active), 1);
        check("e_rearm_post", int'(bif.post_exp_active), 0);
        check("e_rearm_tx", int'(bif.bomb_tx), 4);
        steps(20);

        // Random traffic, pixels biased around the current bomb tile.
        for (int i = 0; i < 3000; i++) begin
            step();
            bif.place = ($urandom_range(9) == 0);
            bif.x_b   = 10'($urandom_range(1023));
            bif.y_b   = 10'($urandom_range(1023));
            if ($urandom_range(1) == 1) begin
                set_pix(m_tx + int'($urandom_range(6)) - 3, m_ty + int'($urandom_range(6)) - 3);
            end else begin
                bif.x = 10'($urandom_range(1023));
                bif.y = 10'($urandom_range(1023));
            end
            if ($urandom_range(499) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
